adc_capture: RTL and testbench

Triggered ADC snapshot buffer: captures paired 12-bit samples from both channels of the `adc` block into on-chip RAM, with decimation and a level/external trigger, so firmware can read a coherent record instead of polling the live `adc.ch1/ch2` CSR values. It sits beside `adc` in `top`. Control inputs come from `soc_csr` hwif_out fields and write strobes. Status and read-data outputs return through hwif_in.

---
 rtl/adc_capture.sv | 172 +++++++++++++++++
 tb/tb_adc_capture.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture
// Purpose  : Triggered snapshot buffer for the two ADC channels. After an arm
//            strobe it waits for a trigger (immediate, ch1 rising/falling
//            through a level, or external), then stores decimated {ch2,ch1}
//            pairs into a simple dual-port RAM until the record is full.
//            Firmware pops the record back one word at a time in DONE.
// Ports    : sys_clk/sys_rst    - clock, synchronous active-high reset
//            adc_ch1/adc_ch2    - live samples (unsigned offset binary)
//            arm/abort          - single-cycle control strobes
//            decim, trig_mode, trig_level, len_m1 - latched on arm
//            trig_ext           - external trigger, sampled on ticks
//            rd_pop             - consume current rd_data
//            rd_data/rd_valid   - readout word and qualifier
//            state/count        - FSM state and words written in the record
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture #(
    parameter int DEPTH = 1024,
    parameter int DW    = 12
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [DW-1:0]              adc_ch1,
    input  logic [DW-1:0]              adc_ch2,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [15:0]                decim,
    input  logic [1:0]                 trig_mode,
    input  logic [DW-1:0]              trig_level,
    input  logic                       trig_ext,
    input  logic [$clog2(DEPTH)-1:0]   len_m1,
    input  logic                       rd_pop,
    output logic [2*DW-1:0]            rd_data,
    output logic                       rd_valid,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_one = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [15:0]        r_decim;
    logic [15:0]        r_dcnt;
    logic [1:0]         r_mode;
    logic [DW-1:0]      r_level;
    logic [AW-1:0]      r_len;
    logic [DW-1:0]      r_prev;
    logic               r_prev_valid;
    // r_count doubles as the write pointer: both start at 0 on arm and
    // advance together on every stored word.
    logic [AW:0]        r_count;
    logic [AW:0]        r_rd_ptr;
    logic               r_rd_valid;
    logic [2*DW-1:0]    r_ram_q;
    logic [2*DW-1:0]    mem [DEPTH];

    logic               w_run;
    logic               w_tick;
    logic               w_trig;
    logic               w_quiet;
    logic               w_fire;
    logic               w_we;
    logic               w_last;
    logic               w_fetch;
    logic               w_pop;
    logic [AW:0]        w_count_nxt;

    assign w_run       = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign w_tick      = w_run && (r_dcnt == r_decim);
    assign w_quiet     = !abort && !arm;
    assign w_count_nxt = r_count + c_one;
    assign w_last      = (w_count_nxt == ({1'b0, r_len} + c_one));

    always_comb begin
        w_trig = 1'b0;
        case (r_mode)
            2'd0:    w_trig = 1'b1;
            2'd1:    w_trig = r_prev_valid && (r_prev <  r_level) && (adc_ch1 >= r_level);
            2'd2:    w_trig = r_prev_valid && (r_prev >= r_level) && (adc_ch1 <  r_level);
            default: w_trig = trig_ext;
        endcase
    end

    assign w_fire  = w_quiet && w_tick && (r_state == S_ARMED) && w_trig;
    assign w_we    = w_fire || (w_quiet && w_tick && (r_state == S_CAPTURE));
    // A new word is fetched whenever nothing is held and words remain.
    assign w_fetch = w_quiet && (r_state == S_DONE) && !r_rd_valid && (r_rd_ptr < r_count);
    assign w_pop   = w_quiet && (r_state == S_DONE) && r_rd_valid && rd_pop;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_decim      <= '0;
            r_dcnt       <= '0;
            r_mode       <= '0;
            r_level      <= '0;
            r_len        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_rd_valid   <= 1'b0;
        end else if (abort) begin
            // count is left intact so firmware can see how far it got
            r_state    <= S_IDLE;
            r_dcnt     <= '0;
            r_rd_valid <= 1'b0;
        end else if (arm) begin
            r_state      <= S_ARMED;
            r_decim      <= decim;
            r_mode       <= trig_mode;
            r_level      <= trig_level;
            r_len        <= len_m1;
            r_dcnt       <= '0;
            r_prev_valid <= 1'b0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            if (!w_run || w_tick) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 16'd1;
            end

            if (w_tick && (r_state == S_ARMED)) begin
                r_prev       <= adc_ch1;
                r_prev_valid <= 1'b1;
            end

            // With len_m1 == 0 the trigger write is also the last write.
            if (w_we) begin
                r_count <= w_count_nxt;
                r_state <= w_last ? S_DONE : S_CAPTURE;
            end

            if (w_pop) begin
                r_rd_valid <= 1'b0;
                r_rd_ptr   <= r_rd_ptr + c_one;
            end else if (w_fetch) begin
                r_rd_valid <= 1'b1;
            end
        end
    end

    // Simple dual-port RAM, registered read, no reset on the array.
    always_ff @(posedge sys_clk) begin
        if (w_we) begin
            mem[r_count[AW-1:0]] <= {adc_ch2, adc_ch1};
        end
        if (w_fetch) begin
            r_ram_q <= mem[r_rd_ptr[AW-1:0]];
        end
    end

    assign rd_data  = r_rd_valid ? r_ram_q : '0;
    assign rd_valid = r_rd_valid;
    assign state    = r_state;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture
// Purpose  : Directed self-checking bench for adc_capture. ADC inputs follow
//            deterministic per-cycle patterns so expected trigger cycles and
//            stored words are computed from the pattern functions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture;

    localparam int DEPTH = 1024;
    localparam int DW    = 12;
    localparam int AW    = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     ch1, ch2;
    logic              arm, abort;
    logic [15:0]       decim;
    logic [1:0]        mode;
    logic [DW-1:0]     level;
    logic              ext;
    logic [AW-1:0]     len_m1;
    logic              rd_pop;
    logic [2*DW-1:0]   rd_data;
    logic              rd_valid;
    logic [1:0]        state;
    logic [AW:0]       count;

    int cyc;
    int pat;
    int checks;
    int failures;

    adc_capture #(.DEPTH(DEPTH), .DW(DW)) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .adc_ch1    (ch1),
        .adc_ch2    (ch2),
        .arm        (arm),
        .abort      (abort),
        .decim      (decim),
        .trig_mode  (mode),
        .trig_level (level),
        .trig_ext   (ext),
        .len_m1     (len_m1),
        .rd_pop     (rd_pop),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .state      (state),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Pattern 0 ramp, 1 triangle 0x700..0x840 (period 40), 2 const 0x100, 3 const 0x900
    function automatic logic [11:0] ch1_of(input int p, input int c);
        int m;
        m = c % 40;
        case (p)
            0:       return 12'(c);
            1:       return (m < 20) ? 12'(32'h700 + m * 16) : 12'(32'h700 + (40 - m) * 16);
            2:       return 12'h100;
            default: return 12'h900;
        endcase
    endfunction

    function automatic logic [11:0] ch2_of(input int p, input int c);
        case (p)
            0:       return 12'hFFF - 12'(c);
            1:       return 12'(c * 5);
            default: return 12'h555;
        endcase
    endfunction

    function automatic logic [23:0] word_of(input int p, input int c);
        return {ch2_of(p, c), ch1_of(p, c)};
    endfunction

    // First tick cycle at which the trigger fires, or -1 if none soon.
    function automatic int find_trig(input int a, input int d, input int md,
                                     input logic [11:0] lv, input int p);
        int t;
        logic [11:0] s, q;
        for (int k = 0; k < 2000; k++) begin
            t = a + 1 + d + k * (d + 1);
            s = ch1_of(p, t);
            q = ch1_of(p, t - (d + 1));
            if (md == 0) return t;
            if (md == 1 && k > 0 && q < lv && s >= lv) return t;
            if (md == 2 && k > 0 && q >= lv && s < lv) return t;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ch1 = ch1_of(pat, cyc);
        ch2 = ch2_of(pat, cyc);
    endtask

    task automatic do_arm(input int d, input int md, input logic [11:0] lv,
                          input int ln, output int a);
        decim  = 16'(d);
        mode   = 2'(md);
        level  = lv;
        len_m1 = 10'(ln);
        a      = cyc;
        arm    = 1'b1;
        step();
        arm    = 1'b0;
    endtask

    task automatic test_reset();
        int a;
        pat = 0;
        do_arm(0, 0, 12'h0, 7, a);
        step(); step(); step();
        rst = 1'b1;
        step();
        checks++;
        if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL reset: state=%0d count=%0d valid=%b data=%h expected 0/0/0/0",
                     state, count, rd_valid, rd_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_immediate();
        int a, t, n;
        logic [23:0] exp;
        pat = 0;
        do_arm(0, 0, 12'h0, 7, a);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL imm_armed: state=%0d expected 1", state);
        end
        t = a + 1;
        n = 0;
        while (state !== 2'd3 && n < 50) begin step(); n++; end
        checks++;
        if (state !== 2'd3 || cyc != a + 9 || count !== 11'd8) begin
            failures++;
            $display("FAIL imm_done: state=%0d at +%0d count=%0d expected 3 at +9 count=8",
                     state, cyc - a, count);
        end
        for (int i = 0; i < 8; i++) begin
            n = 0;
            do begin step(); n++; end while (rd_valid !== 1'b1 && n < 4);
            exp = word_of(pat, t + i);
            checks++;
            if (rd_valid !== 1'b1 || n != 1 || rd_data !== exp) begin
                failures++;
                $display("FAIL imm_word%0d: valid=%b lat=%0d data=%h expected valid=1 lat=1 data=%h",
                         i, rd_valid, n, rd_data, exp);
            end
            rd_pop = 1'b1; step(); rd_pop = 1'b0;
            checks++;
            if (rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL imm_pop%0d: valid=%b expected 0", i, rd_valid);
            end
        end
        step(); step(); step();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL imm_empty: valid=%b expected 0", rd_valid);
        end
    endtask

    task automatic test_rising();
        int a, t, n;
        logic [23:0] exp;
        pat = 1;
        do_arm(3, 1, 12'h800, 15, a);
        t = find_trig(a, 3, 1, 12'h800, 1);
        n = 0;
        while (state !== 2'd3 && n < 400) begin step(); n++; end
        checks++;
        if (state !== 2'd3 || cyc != t + 15 * 4 + 1 || count !== 11'd16) begin
            failures++;
            $display("FAIL rise_done: state=%0d at cyc %0d count=%0d expected 3 at %0d count=16",
                     state, cyc, count, t + 61);
        end
        for (int i = 0; i < 16; i++) begin
            n = 0;
            do begin step(); n++; end while (rd_valid !== 1'b1 && n < 4);
            exp = word_of(pat, t + i * 4);
            checks++;
            if (rd_valid !== 1'b1 || n != 1 || rd_data !== exp) begin
                failures++;
                $display("FAIL rise_word%0d: valid=%b lat=%0d data=%h expected valid=1 lat=1 data=%h",
                         i, rd_valid, n, rd_data, exp);
            end
            rd_pop = 1'b1; step(); rd_pop = 1'b0;
        end
    endtask

    task automatic test_first_tick_guard();
        int a;
        abort = 1'b1; step(); abort = 1'b0;
        pat = 2;
        do_arm(0, 2, 12'h800, 7, a);
        repeat (40) step();
        checks++;
        if (state !== 2'd1 || count !== '0) begin
            failures++;
            $display("FAIL guard_fall: state=%0d count=%0d expected 1/0", state, count);
        end
        // previous tick held 0x100 < level; a steady 0x900 must not look like a rise
        pat = 3;
        do_arm(0, 1, 12'h800, 7, a);
        repeat (40) step();
        checks++;
        if (state !== 2'd1 || count !== '0) begin
            failures++;
            $display("FAIL guard_rise: state=%0d count=%0d expected 1/0", state, count);
        end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_external();
        int a, n;
        pat = 0;
        do_arm(4, 3, 12'h0, 3, a);
        while (cyc < a + 7) step();
        ext = 1'b1; step(); ext = 1'b0;
        while (cyc < a + 13) step();
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL ext_pulse: state=%0d expected 1", state);
        end
        ext = 1'b1;
        while (cyc < a + 16) step();
        ext = 1'b0;
        checks++;
        if (state !== 2'd2 || count !== 11'd1) begin
            failures++;
            $display("FAIL ext_start: state=%0d count=%0d expected 2/1", state, count);
        end
        n = 0;
        while (state !== 2'd3 && n < 40) begin step(); n++; end
        checks++;
        if (state !== 2'd3 || cyc != a + 31) begin
            failures++;
            $display("FAIL ext_done: state=%0d at +%0d expected 3 at +31", state, cyc - a);
        end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_abort_rearm();
        int a, n;
        pat = 0;
        do_arm(0, 0, 12'h0, 99, a);
        n = 0;
        while (count !== 11'd5 && n < 20) begin step(); n++; end
        abort = 1'b1; step(); abort = 1'b0;
        checks++;
        if (state !== 2'd0 || count !== 11'd5 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort: state=%0d count=%0d valid=%b expected 0/5/0", state, count, rd_valid);
        end
        rd_pop = 1'b1; repeat (3) step(); rd_pop = 1'b0;
        step();
        checks++;
        if (state !== 2'd0 || count !== 11'd5 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_pop: state=%0d count=%0d valid=%b expected 0/5/0", state, count, rd_valid);
        end
        do_arm(0, 0, 12'h0, 99, a);
        repeat (3) step();
        arm = 1'b1; step(); arm = 1'b0;
        checks++;
        if (state !== 2'd1 || count !== '0) begin
            failures++;
            $display("FAIL rearm: state=%0d count=%0d expected 1/0", state, count);
        end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_len_one();
        int a;
        pat = 0;
        do_arm(2, 0, 12'h0, 0, a);
        step(); step();
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL len1_armed: state=%0d expected 1", state);
        end
        step();
        checks++;
        if (state !== 2'd3 || count !== 11'd1) begin
            failures++;
            $display("FAIL len1_done: state=%0d count=%0d expected 3/1", state, count);
        end
        step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== word_of(0, a + 3)) begin
            failures++;
            $display("FAIL len1_word: valid=%b data=%h expected 1/%h", rd_valid, rd_data, word_of(0, a + 3));
        end
        rd_pop = 1'b1; step(); rd_pop = 1'b0;
        step(); step();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL len1_empty: valid=%b expected 0", rd_valid);
        end
    endtask

    task automatic test_full_depth();
        int a, t, n, bad;
        logic [23:0] exp;
        pat = 0;
        do_arm(0, 0, 12'h0, DEPTH - 1, a);
        t = a + 1;
        n = 0;
        while (state !== 2'd3 && n < 1200) begin step(); n++; end
        checks++;
        if (state !== 2'd3 || cyc != a + DEPTH + 1 || count !== 11'(DEPTH)) begin
            failures++;
            $display("FAIL depth_done: state=%0d at +%0d count=%0d expected 3 at +%0d count=%0d",
                     state, cyc - a, count, DEPTH + 1, DEPTH);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n = 0;
            do begin step(); n++; end while (rd_valid !== 1'b1 && n < 4);
            exp = word_of(pat, t + i);
            checks++;
            if (rd_valid !== 1'b1 || n != 1 || rd_data !== exp) begin
                failures++;
                if (bad < 5)
                    $display("FAIL depth_word%0d: valid=%b lat=%0d data=%h expected valid=1 lat=1 data=%h",
                             i, rd_valid, n, rd_data, exp);
                bad++;
            end
            rd_pop = 1'b1; step(); rd_pop = 1'b0;
        end
        step();
        rd_pop = 1'b1; step(); rd_pop = 1'b0;
        step(); step();
        checks++;
        if (rd_valid !== 1'b0 || state !== 2'd3 || count !== 11'(DEPTH)) begin
            failures++;
            $display("FAIL depth_overpop: valid=%b state=%0d count=%0d expected 0/3/%0d",
                     rd_valid, state, count, DEPTH);
        end
        arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
        checks++;
        if (state !== 2'd0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL arm_abort: state=%0d valid=%b expected 0/0", state, rd_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        pat      = 0;
        rst      = 1'b1;
        arm      = 1'b0;
        abort    = 1'b0;
        decim    = '0;
        mode     = '0;
        level    = '0;
        ext      = 1'b0;
        len_m1   = '0;
        rd_pop   = 1'b0;
        ch1      = ch1_of(0, 0);
        ch2      = ch2_of(0, 0);
        step(); step();
        rst = 1'b0;
        step();
        test_reset();
        test_immediate();
        test_rising();
        test_first_tick_guard();
        test_external();
        test_abort_rearm();
        test_len_one();
        test_full_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
